// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed-latency req/ready handshake.
// Define MEM_ERR_CHECK_EN to flag unaligned and out-of-range accesses.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          bad;
  logic          fire;

  // With zero latency the response is built straight from the live inputs.
  always_comb begin
    c_we    = (state == IDLE) ? we    : we_q;
    c_addr  = (state == IDLE) ? addr  : addr_q;
    c_wdata = (state == IDLE) ? wdata : wdata_q;
    c_idx   = c_addr[AW+1:2];
    fire    = ((state == IDLE) && req && (LATENCY == 0))
           || ((state == BUSY) && (cnt == 4'd0));
  end

`ifdef MEM_ERR_CHECK_EN
  always_comb begin
    bad = (c_addr[1:0] != 2'b00)
       || ({1'b0, c_addr} >= 33'(DEPTH * 4));
  end
`else
  logic unused_addr;
  assign unused_addr = ^{c_addr[31:AW+2], c_addr[1:0]};
  assign bad = 1'b0;
`endif

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (fire && c_we && !bad)
      mem[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      rdata   <= 32'd0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      ready <= fire;
      err   <= fire & bad;
      if (fire)
        rdata <= (c_we || bad) ? 32'd0 : mem[c_idx];
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= LAT_M1;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0)
            state <= RESP;
          else
            cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, giving the number of 32-bit words in storage; it SHALL be a power of two.
REQ-002 The module SHALL have parameter LATENCY, default 2, giving wait cycles between acceptance and response; legal range is 0..15.
REQ-003 The module SHALL have input clk, 1 bit, as its single clock; all state updates SHALL occur on its rising edge.
REQ-004 The module SHALL have input rst, 1 bit, as the reset; it SHALL be asynchronous and active-high.
REQ-005 The module SHALL have input req, 1 bit, as the request strobe from the multicycle core.
REQ-006 The module SHALL have input we, 1 bit, meaning write when 1 and read when 0.
REQ-007 The module SHALL have input addr, 32 bits, as the byte address.
REQ-008 The module SHALL have input wdata, 32 bits, as the write data.
REQ-009 The module SHALL have output ready, 1 bit, as the response strobe.
REQ-010 The module SHALL have output rdata, 32 bits, as the read data.
REQ-011 The module SHALL have output err, 1 bit, as the access-error flag qualified by ready.

Function
REQ-012 The module SHALL implement a state machine with the states IDLE, BUSY and RESP.
REQ-013 In IDLE, the module SHALL accept a request when req=1 at a rising edge, capturing we, the word index addr[log2(DEPTH)+1:2], addr and wdata.
REQ-014 On acceptance, the next state SHALL be RESP if LATENCY=0; otherwise it SHALL be BUSY with the wait counter loaded to LATENCY-1.
REQ-015 In BUSY, the counter SHALL decrement each cycle; when it is 0 at an edge, the next state SHALL be RESP.
REQ-016 RESP SHALL last exactly one cycle, with ready=1, and SHALL always return to IDLE.
REQ-017 ready SHALL be 0 in IDLE and BUSY, so an accepted request SHALL see ready high exactly LATENCY+1 cycles after its acceptance edge.
REQ-018 req SHALL be ignored in BUSY and RESP, and captured inputs SHALL NOT change while in those states.
REQ-019 Back-to-back requests SHALL require at least one IDLE cycle between them.
REQ-020 On a write, storage[index] SHALL update on the edge that enters RESP, and rdata SHALL be driven to 0 for that response.
REQ-021 On a read, rdata SHALL be loaded with storage[index] on the edge that enters RESP, and it SHALL hold that value until the next response.
REQ-022 A read of a word written by the previous transaction SHALL return the new data.
REQ-023 Storage contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, counter=0, ready=0, rdata=0 and err=0.
REQ-025 Asserting rst during BUSY SHALL abort the transaction: no storage write SHALL occur and no response SHALL be produced.
REQ-026 The first request SHALL be accepted on the first rising edge with rst=0 and req=1.

Configuration
REQ-027 The macro MEM_ERR_CHECK_EN SHALL enable access checking when it is defined.
REQ-028 With MEM_ERR_CHECK_EN defined, a request with addr[1:0]!=0 or addr>=DEPTH*4 SHALL complete with normal timing, ready=1, err=1 and rdata=0.
REQ-029 With MEM_ERR_CHECK_EN defined, an erroring write SHALL leave storage unmodified.
REQ-030 Without MEM_ERR_CHECK_EN, err SHALL be constant 0, addr[1:0] SHALL be ignored, and upper address bits SHALL be discarded, so addresses wrap modulo DEPTH words.

Verification
REQ-031 The bench SHALL cover: with LATENCY=2, write 0xDEADBEEF to 0x10 then read 0x10 -> each ready pulse 3 cycles after acceptance, read rdata=0xDEADBEEF, err=0.
REQ-032 The bench SHALL cover: with LATENCY=0, read at 0x0 after writing 0x00000013 -> ready on the cycle after acceptance, rdata=0x00000013.
REQ-033 The bench SHALL cover: req held high continuously for 10 cycles with LATENCY=2 -> ready pulses every 4 cycles, exactly one per accepted request, never two cycles in a row.
REQ-034 The bench SHALL cover: write 0x11111111 to 0x20, then write 0x22222222 to 0x20 with rst pulsed during BUSY, then read 0x20 -> 0x11111111, and ready stays low during the aborted transaction.
REQ-035 The bench SHALL cover, with MEM_ERR_CHECK_EN: write to 0x22 and read 0x400 with DEPTH=256 -> err=1, rdata=0, and a read of 0x20 is unchanged.
REQ-036 The bench SHALL cover, without MEM_ERR_CHECK_EN: write 0xCAFEF00D to 0x404 then read 0x4 -> rdata=0xCAFEF00D, err=0.
